// File: rtl/dual_stream_sync_fifo_if.sv
// Bundle of the two skewed input pixel streams and the merged 16-bit output stream.
// The slave modport is the FIFO itself; the master modport is whoever drives the sources.
interface dual_stream_sync_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 11
);
  logic              image1_hs;
  logic              image1_vs;
  logic              image1_valid;
  logic [DWIDTH-1:0] image1_data;
  logic              image2_hs;
  logic              image2_vs;
  logic              image2_valid;
  logic [DWIDTH-1:0] image2_data;

  logic                o_image_hs;
  logic                o_image_vs;
  logic                o_image_valid;
  logic [2*DWIDTH-1:0] o_image_data;
  logic [CWIDTH-1:0]   o_fill1;
  logic [CWIDTH-1:0]   o_fill2;
  logic                o_ovf1;
  logic                o_ovf2;

  modport master (
    output image1_hs, image1_vs, image1_valid, image1_data,
    output image2_hs, image2_vs, image2_valid, image2_data,
    input  o_image_hs, o_image_vs, o_image_valid, o_image_data,
    input  o_fill1, o_fill2, o_ovf1, o_ovf2
  );

  modport slave (
    input  image1_hs, image1_vs, image1_valid, image1_data,
    input  image2_hs, image2_vs, image2_valid, image2_data,
    output o_image_hs, o_image_vs, o_image_valid, o_image_data,
    output o_fill1, o_fill2, o_ovf1, o_ovf2
  );
endinterface

// File: rtl/dual_stream_sync_fifo.sv
// Re-aligns two skewed 8-bit pixel streams through per-stream circular FIFOs and emits
// pixel N of both streams together as one 16-bit word, using SOF tags to realign frames.
module dual_stream_sync_fifo #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 11
) (
  input  logic                  pixclk,
  input  logic                  rst,
  output logic                  o_pixclk,
  dual_stream_sync_fifo_if.slave bus
);
  localparam int DEPTH = 1 << AWIDTH;

  typedef logic [DWIDTH:0] entry_t;

  entry_t mem1 [DEPTH];
  entry_t mem2 [DEPTH];

  logic [AWIDTH-1:0]   wrPtr1_q, wrPtr1_d, rdPtr1_q, rdPtr1_d;
  logic [AWIDTH-1:0]   wrPtr2_q, wrPtr2_d, rdPtr2_q, rdPtr2_d;
  logic [CWIDTH-1:0]   fill1_q, fill1_d, fill2_q, fill2_d;
  logic                sofPend1_q, sofPend1_d, sofPend2_q, sofPend2_d;
  logic                ovf1_q, ovf1_d, ovf2_q, ovf2_d;
  logic                outValid_q, outValid_d, outVs_q, outVs_d;
  logic [2*DWIDTH-1:0] outData_q, outData_d;

  logic   wr1, wr2, full1, full2, accept1, accept2, pop1, pop2;
  entry_t head1, head2, wrEntry1, wrEntry2;

  assign head1 = mem1[rdPtr1_q];
  assign head2 = mem2[rdPtr2_q];

  // Pairing decision: matching SOF tags leave together, otherwise the non-SOF head is a
  // stale tail of the previous frame and is dropped so the frames line up again.
  always_comb begin
    pop1       = 1'b0;
    pop2       = 1'b0;
    outValid_d = 1'b0;
    outVs_d    = 1'b0;
    outData_d  = outData_q;
    if (fill1_q != '0 && fill2_q != '0) begin
      if (head1[DWIDTH] == head2[DWIDTH]) begin
        pop1       = 1'b1;
        pop2       = 1'b1;
        outValid_d = 1'b1;
        outVs_d    = head1[DWIDTH];
        outData_d  = {head2[DWIDTH-1:0], head1[DWIDTH-1:0]};
      end else if (!head1[DWIDTH]) begin
        pop1 = 1'b1;
      end else begin
        pop2 = 1'b1;
      end
    end
  end

  // A write into a full FIFO only survives when that FIFO frees a slot in the same cycle.
  always_comb begin
    wr1        = bus.image1_valid & bus.image1_hs;
    wr2        = bus.image2_valid & bus.image2_hs;
    full1      = (fill1_q == CWIDTH'(DEPTH));
    full2      = (fill2_q == CWIDTH'(DEPTH));
    accept1    = wr1 & (~full1 | pop1);
    accept2    = wr2 & (~full2 | pop2);
    wrEntry1   = {bus.image1_vs | sofPend1_q, bus.image1_data};
    wrEntry2   = {bus.image2_vs | sofPend2_q, bus.image2_data};
    wrPtr1_d   = wrPtr1_q + AWIDTH'(accept1);
    wrPtr2_d   = wrPtr2_q + AWIDTH'(accept2);
    rdPtr1_d   = rdPtr1_q + AWIDTH'(pop1);
    rdPtr2_d   = rdPtr2_q + AWIDTH'(pop2);
    fill1_d    = fill1_q + CWIDTH'(accept1) - CWIDTH'(pop1);
    fill2_d    = fill2_q + CWIDTH'(accept2) - CWIDTH'(pop2);
    sofPend1_d = accept1 ? 1'b0 : (sofPend1_q | bus.image1_vs);
    sofPend2_d = accept2 ? 1'b0 : (sofPend2_q | bus.image2_vs);
    ovf1_d     = ovf1_q | (wr1 & ~accept1);
    ovf2_d     = ovf2_q | (wr2 & ~accept2);
  end

  always_ff @(posedge pixclk) begin
    if (accept1) mem1[wrPtr1_q] <= wrEntry1;
    if (accept2) mem2[wrPtr2_q] <= wrEntry2;
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      wrPtr1_q   <= '0;
      wrPtr2_q   <= '0;
      rdPtr1_q   <= '0;
      rdPtr2_q   <= '0;
      fill1_q    <= '0;
      fill2_q    <= '0;
      sofPend1_q <= 1'b0;
      sofPend2_q <= 1'b0;
      ovf1_q     <= 1'b0;
      ovf2_q     <= 1'b0;
      outValid_q <= 1'b0;
      outVs_q    <= 1'b0;
      outData_q  <= '0;
    end else begin
      wrPtr1_q   <= wrPtr1_d;
      wrPtr2_q   <= wrPtr2_d;
      rdPtr1_q   <= rdPtr1_d;
      rdPtr2_q   <= rdPtr2_d;
      fill1_q    <= fill1_d;
      fill2_q    <= fill2_d;
      sofPend1_q <= sofPend1_d;
      sofPend2_q <= sofPend2_d;
      ovf1_q     <= ovf1_d;
      ovf2_q     <= ovf2_d;
      outValid_q <= outValid_d;
      outVs_q    <= outVs_d;
      outData_q  <= outData_d;
    end
  end

  assign o_pixclk          = pixclk;
  assign bus.o_image_hs    = outValid_q;
  assign bus.o_image_valid = outValid_q;
  assign bus.o_image_vs    = outVs_q;
  assign bus.o_image_data  = outData_q;
  assign bus.o_fill1       = fill1_q;
  assign bus.o_fill2       = fill2_q;
  assign bus.o_ovf1        = ovf1_q;
  assign bus.o_ovf2        = ovf2_q;
endmodule

// File: tb/tb_dual_stream_sync_fifo.sv
// Bench for dual_stream_sync_fifo: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the two tagged FIFOs and the pairing rule.
module tb_dual_stream_sync_fifo;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int CW = 11;
  localparam int DEPTH = 1 << AW;
  localparam int VW = 3 + 2*DW + 2*CW + 2;

  logic pixclk = 1'b0;
  logic rst = 1'b1;
  logic oPixclk;

  always #5 pixclk = ~pixclk;

  dual_stream_sync_fifo_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

  dual_stream_sync_fifo #(.AWIDTH(AW), .DWIDTH(DW), .CWIDTH(CW)) dut (
    .pixclk  (pixclk),
    .rst     (rst),
    .o_pixclk(oPixclk),
    .bus     (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each FIFO is a queue of {sof,data}; the output registers are plain variables.
  logic [DW:0]     q1[$];
  logic [DW:0]     q2[$];
  logic            pend1 = 1'b0, pend2 = 1'b0;
  logic            mOvf1 = 1'b0, mOvf2 = 1'b0;
  logic            mValid = 1'b0, mVs = 1'b0;
  logic [2*DW-1:0] mData = '0;

  task automatic applyStimulus(input logic hs1, vs1, val1, input logic [DW-1:0] d1,
                               input logic hs2, vs2, val2, input logic [DW-1:0] d2);
    bus.image1_hs = hs1; bus.image1_vs = vs1; bus.image1_valid = val1; bus.image1_data = d1;
    bus.image2_hs = hs2; bus.image2_vs = vs2; bus.image2_valid = val2; bus.image2_data = d2;
  endtask

  // One clock edge: the model consumes the inputs held during the cycle, then outputs settle.
  task automatic advanceCycle();
    logic wr1, wr2, p1, p2, a1, a2, s1, s2;
    @(posedge pixclk);
    wr1 = bus.image1_valid & bus.image1_hs;
    wr2 = bus.image2_valid & bus.image2_hs;
    if (rst) begin
      q1.delete(); q2.delete();
      pend1 = 0; pend2 = 0; mOvf1 = 0; mOvf2 = 0;
      mValid = 0; mVs = 0; mData = '0;
    end else begin
      p1 = 0; p2 = 0; mValid = 0; mVs = 0;
      if (q1.size() > 0 && q2.size() > 0) begin
        if (q1[0][DW] == q2[0][DW]) begin
          p1 = 1; p2 = 1; mValid = 1; mVs = q1[0][DW];
          mData = {q2[0][DW-1:0], q1[0][DW-1:0]};
        end else if (q1[0][DW] == 1'b0) p1 = 1;
        else p2 = 1;
      end
      a1 = wr1 && (q1.size() < DEPTH || p1);
      a2 = wr2 && (q2.size() < DEPTH || p2);
      if (wr1 && !a1) mOvf1 = 1;
      if (wr2 && !a2) mOvf2 = 1;
      s1 = bus.image1_vs | pend1;
      s2 = bus.image2_vs | pend2;
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (a1) q1.push_back({s1, bus.image1_data});
      if (a2) q2.push_back({s2, bus.image2_data});
      if (a1) pend1 = 0; else if (bus.image1_vs) pend1 = 1;
      if (a2) pend2 = 0; else if (bus.image2_vs) pend2 = 1;
    end
    #1;
  endtask

  function automatic logic [VW-1:0] modelVec();
    return {mValid, mVs, mValid, mData, CW'(q1.size()), CW'(q2.size()), mOvf1, mOvf2};
  endfunction

  function automatic logic [VW-1:0] dutVec();
    return {bus.o_image_valid, bus.o_image_vs, bus.o_image_hs, bus.o_image_data,
            bus.o_fill1, bus.o_fill2, bus.o_ovf1, bus.o_ovf2};
  endfunction

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    advanceCycle();
    advanceCycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    repeat (3) advanceCycle();
    checks++; if (bus.o_image_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0h expected 0", bus.o_image_valid); end
    checks++; if (bus.o_image_hs !== 1'b0) begin failures++; $display("[TB] FAIL reset_hs: got %0h expected 0", bus.o_image_hs); end
    checks++; if (bus.o_image_vs !== 1'b0) begin failures++; $display("[TB] FAIL reset_vs: got %0h expected 0", bus.o_image_vs); end
    checks++; if (bus.o_image_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data: got %0h expected 0", bus.o_image_data); end
    checks++; if (bus.o_fill1 !== 11'd0) begin failures++; $display("[TB] FAIL reset_fill1: got %0d expected 0", bus.o_fill1); end
    checks++; if (bus.o_fill2 !== 11'd0) begin failures++; $display("[TB] FAIL reset_fill2: got %0d expected 0", bus.o_fill2); end
    checks++; if (bus.o_ovf1 !== 1'b0 || bus.o_ovf2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %0h%0h expected 00", bus.o_ovf1, bus.o_ovf2); end
    checks++; if (oPixclk !== pixclk) begin failures++; $display("[TB] FAIL pixclk_pass: got %0h expected %0h", oPixclk, pixclk); end
  endtask

  // Stream 2 lags stream 1 by five cycles; pairs must come out realigned with vs on the first.
  task automatic test_skewed_pairs();
    logic [DW-1:0] b;
    logic          expValid;
    int            pairs = 0;
    doReset();
    for (int c = 0; c < 22; c++) begin
      applyStimulus(c < 10, c == 0, c < 10, DW'(c),
                    c >= 5 && c < 15, c == 5, c >= 5 && c < 15, DW'(c - 5));
      advanceCycle();
      expValid = (c >= 6 && c <= 15);
      if (bus.o_image_valid === 1'b1) pairs++;
      checks++; if (bus.o_image_valid !== expValid) begin failures++; $display("[TB] FAIL skew_valid c=%0d: got %0h expected %0h", c, bus.o_image_valid, expValid); end
      checks++; if (bus.o_image_vs !== (c == 6)) begin failures++; $display("[TB] FAIL skew_vs c=%0d: got %0h expected %0h", c, bus.o_image_vs, c == 6); end
      if (c >= 6) begin
        b = DW'((c - 6 > 9) ? 9 : c - 6);
        checks++; if (bus.o_image_data !== {b, b}) begin failures++; $display("[TB] FAIL skew_data c=%0d: got %0h expected %0h", c, bus.o_image_data, {b, b}); end
      end
      if (c == 4) begin
        checks++; if (bus.o_fill1 !== 11'd5) begin failures++; $display("[TB] FAIL skew_fill1_peak: got %0d expected 5", bus.o_fill1); end
      end
    end
    checks++; if (pairs != 10) begin failures++; $display("[TB] FAIL skew_pair_count: got %0d expected 10", pairs); end
  endtask

  task automatic test_overflow();
    doReset();
    for (int i = 0; i < 1030; i++) begin
      applyStimulus(1, 0, 1, DW'($urandom), 0, 0, 0, 0);
      advanceCycle();
      if (i == DEPTH - 1) begin
        checks++; if (bus.o_ovf1 !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early: got %0h expected 0", bus.o_ovf1); end
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    advanceCycle();
    checks++; if (bus.o_fill1 !== 11'd1024) begin failures++; $display("[TB] FAIL ovf_fill1: got %0d expected 1024", bus.o_fill1); end
    checks++; if (bus.o_ovf1 !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag1: got %0h expected 1", bus.o_ovf1); end
    checks++; if (bus.o_ovf2 !== 1'b0) begin failures++; $display("[TB] FAIL ovf_flag2: got %0h expected 0", bus.o_ovf2); end
    checks++; if (bus.o_image_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_valid: got %0h expected 0", bus.o_image_valid); end
    repeat (20) advanceCycle();
    checks++; if (bus.o_ovf1 !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %0h expected 1", bus.o_ovf1); end
    doReset();
    #1;
    checks++; if (bus.o_ovf1 !== 1'b0 || bus.o_fill1 !== 11'd0) begin failures++; $display("[TB] FAIL ovf_clear: got ovf=%0h fill=%0d expected 0/0", bus.o_ovf1, bus.o_fill1); end
  endtask

  // Stream 1 fills completely, then both streams run: the full-FIFO writes ride on the pops.
  task automatic test_full_with_pop();
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 1, DW'($urandom), 0, 0, 0, 0);
      advanceCycle();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 1, DW'($urandom));
    advanceCycle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, DW'($urandom), 1, 0, 1, DW'($urandom));
      advanceCycle();
      checks++; if (dutVec() !== modelVec()) begin failures++; $display("[TB] FAIL fullpop_state i=%0d: got %0h expected %0h", i, dutVec(), modelVec()); end
    end
    checks++; if (bus.o_fill1 !== 11'd1024 || bus.o_ovf1 !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_accept: got fill=%0d ovf=%0h expected 1024/0", bus.o_fill1, bus.o_ovf1); end
  endtask

  // Three stale non-SOF entries sit ahead of stream 2's SOF and must be thrown away.
  task automatic test_stale_discard();
    logic [2*DW-1:0] expData;
    doReset();
    for (int c = 0; c < 14; c++) begin
      applyStimulus(c >= 3 && c <= 6, c == 3, c >= 3 && c <= 6, DW'(8'h11 + c - 3),
                    c <= 6, c == 3, c <= 6, DW'((c < 3) ? (8'hA0 + c) : (8'h22 + c - 3)));
      advanceCycle();
      checks++; if (bus.o_image_valid !== (c >= 7 && c <= 10)) begin failures++; $display("[TB] FAIL stale_valid c=%0d: got %0h expected %0h", c, bus.o_image_valid, c >= 7 && c <= 10); end
      if (c >= 7 && c <= 10) begin
        expData = {DW'(8'h22 + c - 7), DW'(8'h11 + c - 7)};
        checks++; if (bus.o_image_data !== expData) begin failures++; $display("[TB] FAIL stale_data c=%0d: got %0h expected %0h", c, bus.o_image_data, expData); end
        checks++; if (bus.o_image_vs !== (c == 7)) begin failures++; $display("[TB] FAIL stale_vs c=%0d: got %0h expected %0h", c, bus.o_image_vs, c == 7); end
      end
      if (c == 6) begin
        checks++; if (bus.o_fill1 !== 11'd4 || bus.o_fill2 !== 11'd4) begin failures++; $display("[TB] FAIL stale_fills: got %0d/%0d expected 4/4", bus.o_fill1, bus.o_fill2); end
      end
    end
  endtask

  // Random bursts, random SOFs and a mid-stream reset, compared cycle by cycle with the model.
  task automatic test_random();
    doReset();
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 1500 || c == 1501);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0, DW'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 4) != 0, DW'($urandom));
      advanceCycle();
      checks++; if (dutVec() !== modelVec()) begin failures++; $display("[TB] FAIL random_state c=%0d: got %0h expected %0h", c, dutVec(), modelVec()); end
    end
    rst = 1'b0;
  endtask

  // Scaled-down frames: identical pixel sequences on both streams, stream 2 delayed.
  task automatic test_frames();
    localparam int W = 32, H = 6, LB = 8, FB = 5, D = 150;
    logic [DW+2:0] tl[$];
    logic [DW+2:0] e1, e2;
    int pairs = 0, vsSeen = 0;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) tl.push_back({1'b0, 1'b1, 1'b0, DW'(0)});
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) tl.push_back({1'b1, f == 1 && y == 0 && x == 0, 1'b1, DW'($urandom)});
        for (int b = 0; b < LB; b++) tl.push_back('0);
      end
      for (int b = 0; b < FB * (W + LB); b++) tl.push_back('0);
    end
    doReset();
    for (int c = 0; c < tl.size() + D + 10; c++) begin
      e1 = (c < tl.size()) ? tl[c] : '0;
      e2 = (c >= D && c - D < tl.size()) ? tl[c - D] : '0;
      applyStimulus(e1[DW+2], e1[DW+1], e1[DW], e1[DW-1:0], e2[DW+2], e2[DW+1], e2[DW], e2[DW-1:0]);
      advanceCycle();
      checks++; if (dutVec() !== modelVec()) begin failures++; $display("[TB] FAIL frames_state c=%0d: got %0h expected %0h", c, dutVec(), modelVec()); end
      if (bus.o_image_valid === 1'b1) begin
        pairs++;
        if (bus.o_image_vs === 1'b1) vsSeen++;
        checks++; if (bus.o_image_data[2*DW-1:DW] !== bus.o_image_data[DW-1:0]) begin failures++; $display("[TB] FAIL frames_pair_equal c=%0d: got %0h expected equal bytes", c, bus.o_image_data); end
      end
    end
    checks++; if (pairs != 2 * W * H) begin failures++; $display("[TB] FAIL frames_pair_count: got %0d expected %0d", pairs, 2 * W * H); end
    checks++; if (vsSeen != 2) begin failures++; $display("[TB] FAIL frames_vs_count: got %0d expected 2", vsSeen); end
    checks++; if (bus.o_ovf1 !== 1'b0 || bus.o_ovf2 !== 1'b0) begin failures++; $display("[TB] FAIL frames_ovf: got %0h%0h expected 00", bus.o_ovf1, bus.o_ovf2); end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_skewed_pairs();
    test_overflow();
    test_full_with_pop();
    test_stale_discard();
    test_random();
    test_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
